// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and oversampling constants shared by the UART receiver files.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/baud_gen.sv
// baud_gen: one-clock tick at OVERSAMPLE times the baud rate, derived by dividing the system clock.
module baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CNT_W'(DIV - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 UART receiver with a valid/ready byte output and sticky overrun.
// Defining UART_RX_PARITY_EN adds an even-parity bit after bit 7 and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);
`ifdef UART_RX_PARITY_EN
    localparam logic [3:0] LAST_IDX  = 4'd8;
`else
    localparam logic [3:0] LAST_IDX  = 4'd7;
`endif

    logic       w_tick;
    logic       r_rx_meta, r_rx_s;
    state_t     r_state, w_state_nxt;
    logic [3:0] r_tick_cnt, r_bit_idx;
    logic [7:0] r_shift, r_rx_data;
    logic       r_rx_valid, r_frame_err, r_overrun;
    logic       w_cnt_clr, w_sample, w_stop, w_load;

    baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud_gen (
        .i_clk  (clk),
        .i_rst  (!reset_n),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_sample    = 1'b0;
        w_stop      = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt = START;
                        w_cnt_clr   = 1'b1;
                    end
                end
                START: begin
                    // A start bit that has gone high again by mid-bit is treated as a glitch.
                    if (r_tick_cnt == MID_TICK) begin
                        w_state_nxt = r_rx_s ? IDLE : DATA;
                        w_cnt_clr   = 1'b1;
                    end
                end
                DATA: begin
                    if (r_tick_cnt == LAST_TICK) begin
                        w_sample = 1'b1;
                        if (r_bit_idx == LAST_IDX) begin
                            w_state_nxt = STOP;
                            w_cnt_clr   = 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (r_tick_cnt == LAST_TICK) begin
                        w_stop      = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_clr   = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            if (w_cnt_clr)                      r_tick_cnt <= '0;
            else if (w_tick && r_state != IDLE) r_tick_cnt <= r_tick_cnt + 1'b1;

            if (w_cnt_clr)     r_bit_idx <= '0;
            else if (w_sample) r_bit_idx <= r_bit_idx + 1'b1;

            if (w_sample && !r_bit_idx[3]) r_shift[r_bit_idx[2:0]] <= r_rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par, r_parity_err, w_par_ok;

    assign w_par_ok = ~(^{r_shift, r_par});
    assign w_load   = w_stop & r_rx_s & w_par_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_sample && r_bit_idx == LAST_IDX) r_par <= r_rx_s;
            r_parity_err <= w_stop & r_rx_s & ~w_par_ok;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign w_load = w_stop & r_rx_s;
`endif

    // A completed byte always wins over a same-cycle handshake; overrun only if nobody took the old one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop & ~r_rx_s;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !rx_ready) r_overrun <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_busy   = (r_state != IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in baud.
REQ-003 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-007 rx_data  output  8  received byte, LSB first on the line.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_busy  output  1  high whenever state != IDLE.
REQ-010 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 overrun  output  1  sticky: a byte completed while rx_valid was still high; cleared only by reset.

Function
REQ-012 rx shall pass through a 2-flop synchronizer (reset value 1) before any use; only the synchronized rx_s is used.
REQ-013 Oversample tick shall be one clk pulse at 16*BAUD_RATE; tick_count (4 bit) advances only on ticks.
REQ-014 States: IDLE, START, DATA, STOP.
REQ-015 IDLE: on a tick with rx_s==0 -> START, tick_count=0, no other condition needed.
REQ-016 START: at tick_count==7 (mid-bit), if rx_s==1 -> IDLE (glitch rejected, no output); else tick_count=0, bit_idx=0 -> DATA.
REQ-017 DATA: at each tick_count==15 the next mid-bit is reached; shall sample rx_s into shift[bit_idx] on that tick; after bit_idx 7 -> STOP, tick_count=0.
REQ-018 STOP: at tick_count==15, sample rx_s; if 1, load rx_data=shift, assert rx_valid next clk; if 0, pulse frame_err, rx_data/rx_valid unchanged; either way -> IDLE.
REQ-019 rx_valid shall stay high until the clk where rx_valid&&rx_ready; it clears on that clk.
REQ-020 Completion with rx_valid high and no handshake on the same clk: new byte overwrites rx_data, rx_valid stays high, overrun set.
REQ-021 Completion on the same clk as a handshake: rx_valid stays high with new data, overrun not set.
REQ-022 Latency: rx_valid rises within one clk of the STOP mid-bit tick; a new frame may begin on the tick after return to IDLE.
REQ-023 rx_ready is ignored when rx_valid is low.

Reset
REQ-024 reset_n low: state=IDLE, tick_count=0, bit_idx=0, shift=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, synchronizer=1, rx_busy=0.
REQ-025 reset_n asserted mid-frame shall abort the frame with no output; after release the receiver waits for a new falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: one even-parity bit follows bit 7 and is sampled like a data bit; mismatch pulses output parity_err (1 bit, reset 0) and suppresses rx_valid; stop check per REQ-018.
REQ-027 UART_RX_PARITY_EN undefined: 8N1 frame, no parity_err port, no parity logic.

Structure
REQ-028 Package uart_pkg shall hold state_t (2-bit enum IDLE/START/DATA/STOP), OVERSAMPLE=16, MID_SAMPLE=7.
REQ-029 The tick source shall be the existing baud_gen sub-module instantiated with CLK_FREQ/BAUD_RATE, reset driven by !reset_n; no other sub-modules.

Verification (CLK_FREQ=2_457_600, BAUD_RATE=9600: tick every 16 clk, bit=256 clk)
REQ-030 Frame 0xA5 (8N1), rx_ready=1 -> rx_data=0xA5, rx_valid high one clk, frame_err=0, overrun=0.
REQ-031 rx low for 64 clk then high -> no rx_valid, rx_busy returns 0, state IDLE.
REQ-032 Frame 0x3C with stop bit low -> frame_err one-clk pulse, rx_valid stays 0, rx_data unchanged.
REQ-033 rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x22, rx_valid=1, overrun=1 until reset.
REQ-034 reset_n low for 10 clk during bit 3 of 0x55, then frame 0x0F -> only 0x0F delivered.
REQ-035 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; parity bit 1 -> rx_data=0x07, rx_valid.
